// File: rtl/fifo_skew_reader.sv
// Diagonal-skew drain stage between the per-lane FIFO array and the systolic PE row.
// Define FSR_STALL_CNT_EN to add the saturating stall_cnt output.
module fifo_skew_reader #(
  parameter int data_size  = 8,
  parameter int array_size = 9,
  parameter int fifo_depth = 256,
  parameter int log_depth  = 8
) (
  input  logic                            r_clk,
  input  logic                            clear,
  input  logic                            start,
  input  logic [log_depth:0]              len,
  input  logic [array_size-1:0]           empty,
  input  logic [array_size*data_size-1:0] fifo_data,
  output logic [array_size-1:0]           r_en,
  output logic [array_size*data_size-1:0] out_data,
  output logic [array_size-1:0]           out_valid,
  output logic                            busy,
  output logic                            done
`ifdef FSR_STALL_CNT_EN
  ,
  output logic [15:0]                     stall_cnt
`endif
);

  localparam int t_width = log_depth + 1 + $clog2(array_size);
  localparam logic [log_depth:0] max_len = (log_depth + 1)'(fifo_depth);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, next_state;
  logic [t_width-1:0]   t;
  logic [log_depth:0]   len_q;
  logic [log_depth:0]   len_sat;
  logic [t_width-1:0]   last_t;
  logic [array_size-1:0] due;
  logic                 stall;
  logic                 accept;
  logic                 advance;

  assign len_sat = (len > max_len) ? max_len : len;
  assign last_t  = t_width'(len_q) + t_width'(array_size - 2);

  // Lane i is due while the wavefront front t lies inside its window [i, i+len_q).
  always_comb begin
    due = '0;
    for (int i = 0; i < array_size; i++) begin
      due[i] = (t >= t_width'(i)) && (t < t_width'(i) + t_width'(len_q));
    end
  end

  assign stall = (state == RUN) && (|(due & empty));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    r_en       = '0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start && (len != '0)) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!stall) begin
          r_en    = due;
          advance = 1'b1;
          if (t == last_t) next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge r_clk) begin
    if (clear) begin
      state     <= IDLE;
      t         <= '0;
      len_q     <= '0;
      out_valid <= '0;
    end else begin
      state     <= next_state;
      out_valid <= r_en;
      if (accept) begin
        len_q <= len_sat;
        t     <= '0;
      end else if (advance) begin
        t <= t + t_width'(1);
      end
    end
  end

  // FIFO dataOut lags r_en by one cycle, matching out_valid; idle lanes are forced to zero.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < array_size; i++) begin
      if (out_valid[i]) out_data[i*data_size +: data_size] = fifo_data[i*data_size +: data_size];
    end
  end

`ifdef FSR_STALL_CNT_EN
  always_ff @(posedge r_clk) begin
    if (clear || accept) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_skew_reader.sv
// Directed bench for fifo_skew_reader: a queue-based FIFO array model feeds the DUT and
// hand-computed cycle expectations are checked with immediate assertions.
module tb_fifo_skew_reader;

  logic        r_clk = 1'b0;
  logic        clear;
  logic        start;
  logic [8:0]  len;
  logic [8:0]  empty;
  logic [71:0] fifo_data;
  logic [8:0]  r_en;
  logic [71:0] out_data;
  logic [8:0]  out_valid;
  logic        busy;
  logic        done;
`ifdef FSR_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [7:0] q [0:8][$];
  int total = 0;
  int bad   = 0;

  always #5 r_clk = ~r_clk;

  fifo_skew_reader dut (
    .r_clk     (r_clk),
    .clear     (clear),
    .start     (start),
    .len       (len),
    .empty     (empty),
    .fifo_data (fifo_data),
    .r_en      (r_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
`ifdef FSR_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    for (int i = 0; i < 9; i++) empty[i] = (q[i].size() == 0);
  endtask

  task automatic push(input int lane, input logic [7:0] v);
    q[lane].push_back(v);
    upd_empty();
  endtask

  // Lane-tagged words are 16*lane+k; plain words are just k.
  task automatic preload(input int n, input bit lane_tag);
    for (int i = 0; i < 9; i++)
      for (int k = 0; k < n; k++)
        push(i, lane_tag ? 8'(16 * i + k) : 8'(k));
  endtask

  // One clock: the FIFO model reacts to the r_en/clear seen before the edge.
  task automatic step();
    logic [8:0] ren;
    logic       clr;
    ren = r_en;
    clr = clear;
    @(posedge r_clk);
    #1;
    if (clr) begin
      for (int i = 0; i < 9; i++) q[i].delete();
      fifo_data = '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (ren[i]) begin
          check($sformatf("underflow_l%0d", i), q[i].size() != 0, 1);
          if (q[i].size() != 0) fifo_data[i*8 +: 8] = q[i].pop_front();
        end
      end
    end
    upd_empty();
  endtask

  initial begin
    int done_c, n0, n8;
    logic [7:0] last8;
    logic [7:0] exp_d;

    clear = 1'b1; start = 1'b1; len = 9'd4; empty = '1; fifo_data = '0;

    // Reset held with start active
    for (int c = 0; c < 2; c++) begin
      step(); #2;
      check("rst_ren", r_en, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    clear = 1'b0; start = 1'b0; len = 9'd0;
    step();

    // Unstalled pass, len=4
    preload(4, 1'b1);
    start = 1'b1; len = 9'd4;
    step();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      #2;
      exp_d = (c >= 10 && c <= 13) ? 8'h80 + 8'(c - 10) : 8'h00;
      check($sformatf("t2_ren0@%0d", c), r_en[0], (c >= 1 && c <= 4));
      check($sformatf("t2_ren8@%0d", c), r_en[8], (c >= 9 && c <= 12));
      check($sformatf("t2_valid8@%0d", c), out_valid[8], (c >= 10 && c <= 13));
      check($sformatf("t2_data8@%0d", c), out_data[71:64], exp_d);
      check($sformatf("t2_done@%0d", c), done, (c == 13));
      check($sformatf("t2_busy@%0d", c), busy, (c <= 13));
      step();
    end
    check("t2_drained", empty, 9'h1FF);

    // Stall: lane 3 has one word, refilled at cycle 9 -> stalls in cycles 5..8
    for (int i = 0; i < 9; i++)
      for (int k = 0; k < ((i == 3) ? 1 : 2); k++) push(i, 8'(16 * i + k));
    start = 1'b1; len = 9'd2;
    step();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 9) push(3, 8'h31);
      #2;
      check($sformatf("t3_no_read_empty@%0d", c), r_en & empty, 0);
      if (c == 4) check("t3_ren@4", r_en, 9'h00C);
      if (c >= 5 && c <= 8) check($sformatf("t3_stall_ren@%0d", c), r_en, 0);
      if (c == 9) check("t3_ren@9", r_en, 9'h018);
      if (c == 10) check("t3_ren@10", r_en, 9'h030);
      if (c >= 6 && c <= 9) check($sformatf("t3_bubble@%0d", c), out_valid, 0);
      if (c == 5) begin
        check("t3_valid@5", out_valid, 9'h00C);
        check("t3_data3@5", out_data[31:24], 8'h30);
        check("t3_data2@5", out_data[23:16], 8'h21);
      end
      if (c == 10) begin
        check("t3_data3@10", out_data[31:24], 8'h31);
        check("t3_data4@10", out_data[39:32], 8'h40);
      end
      check($sformatf("t3_done@%0d", c), done, (c == 15));
      step();
    end
    check("t3_drained", empty, 9'h1FF);
`ifdef FSR_STALL_CNT_EN
    #2;
    check("t3_stall_cnt", stall_cnt, 16'd4);
`endif

    // len=0 is ignored
    start = 1'b1; len = 9'd0;
    step(); #2;
    check("t4_len0_busy", busy, 0);
    check("t4_len0_ren", r_en, 0);
    start = 1'b0;
    step(); #2;
    check("t4_len0_busy2", busy, 0);

    // len=300 saturates to 256; start pulses mid-run are ignored
    preload(256, 1'b0);
    start = 1'b1; len = 9'd300;
    step();
    start = 1'b0;
    done_c = 0; n0 = 0; n8 = 0; last8 = '0;
    for (int c = 1; c <= 400; c++) begin
      if (c == 20 || c == 21) begin
        start = 1'b1; len = 9'd5;
      end else begin
        start = 1'b0;
      end
      #2;
`ifdef FSR_STALL_CNT_EN
      if (c == 1) check("t4_stall_cnt_reset", stall_cnt, 16'd0);
`endif
      check($sformatf("t4_no_read_empty@%0d", c), r_en & empty, 0);
      if (r_en[0]) n0++;
      if (r_en[8]) n8++;
      if (done) begin
        done_c = c;
        last8  = out_data[71:64];
        step();
        break;
      end
      step();
    end
    start = 1'b0;
    #2;
    check("t4_done_cycle", done_c, 265);
    check("t4_reads_l0", n0, 256);
    check("t4_reads_l8", n8, 256);
    check("t4_last_word_l8", last8, 8'hFF);
    check("t4_busy_after", busy, 0);
    check("t4_drained", empty, 9'h1FF);
    step();

    // Abort with clear at cycle 5 of a len=8 pass
    preload(8, 1'b1);
    start = 1'b1; len = 9'd8;
    step();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #2;
      check($sformatf("t5_ren0@%0d", c), r_en[0], 1);
      if (c == 5) clear = 1'b1;
      step();
    end
    #2;
    check("t5_abort_ren", r_en, 0);
    check("t5_abort_valid", out_valid, 0);
    check("t5_abort_data", out_data, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_done", done, 0);
    clear = 1'b0;
    step();
    preload(2, 1'b1);
    start = 1'b1; len = 9'd2;
    step();
    start = 1'b0;
    done_c = 0;
    for (int c = 1; c <= 30; c++) begin
      #2;
      if (c == 3) begin
        check("t5_valid1@3", out_valid[1], 1);
        check("t5_data1@3", out_data[15:8], 8'h10);
      end
      if (done) begin
        done_c = c;
        step();
        break;
      end
      step();
    end
    check("t5_done_cycle", done_c, 11);
`ifdef FSR_STALL_CNT_EN
    check("t5_stall_cnt", stall_cnt, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
